// File: rtl/imem_boot_seq.sv
// Boot sequencer: streams load_count words into instruction memory, then runs the CPU for run_cycles.
// Writes land one cycle after each s_valid/s_ready transfer; s_ready is withheld outside LOAD.
module imem_boot_seq #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic [15:0]       run_cycles,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic [DATA_W-1:0] w_instruction,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [ADDR_W:0]     rem, rem_nxt;
  logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [15:0]         run_left, run_left_nxt;
  logic                run_inf, run_inf_nxt;
  logic                err_nxt, s_ready_nxt, w_enable_nxt, cpu_en_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0]   w_adrs_nxt;
  logic [DATA_W-1:0]   w_instr_nxt;
  logic                xfer;

  // abort masks the handshake so a word offered alongside it is never written
  assign xfer = (state == LOAD) && s_ready && s_valid && !abort;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      rem           <= '0;
      wr_ptr        <= '0;
      run_left      <= '0;
      run_inf       <= 1'b0;
      err           <= 1'b0;
      s_ready       <= 1'b0;
      w_enable      <= 1'b0;
      w_adrs        <= '0;
      w_instruction <= '0;
      cpu_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      rem           <= rem_nxt;
      wr_ptr        <= wr_ptr_nxt;
      run_left      <= run_left_nxt;
      run_inf       <= run_inf_nxt;
      err           <= err_nxt;
      s_ready       <= s_ready_nxt;
      w_enable      <= w_enable_nxt;
      w_adrs        <= w_adrs_nxt;
      w_instruction <= w_instr_nxt;
      cpu_en        <= cpu_en_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    wr_ptr_nxt   = wr_ptr;
    run_left_nxt = run_left;
    run_inf_nxt  = run_inf;
    err_nxt      = err;
    w_enable_nxt = 1'b0;
    w_adrs_nxt   = w_adrs;
    w_instr_nxt  = w_instruction;
    cpu_en_nxt   = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
      if (state == LOAD || state == RUN) err_nxt = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wr_ptr_nxt   = load_base;
            rem_nxt      = load_count;
            run_left_nxt = run_cycles;
            run_inf_nxt  = (run_cycles == 16'd0);
            err_nxt      = 1'b0;
            state_nxt    = (load_count != '0) ? LOAD : RUN;
          end
        end
        LOAD: begin
          if (xfer) begin
            w_enable_nxt = 1'b1;
            w_adrs_nxt   = wr_ptr;
            w_instr_nxt  = s_data;
            wr_ptr_nxt   = wr_ptr + PTR_ONE;
            rem_nxt      = rem - CNT_ONE;
          end else if (rem == '0) begin
            // the final write strobe is on the bus this cycle
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (run_inf) begin
            cpu_en_nxt = 1'b1;
          end else if (run_left != 16'd0) begin
            cpu_en_nxt   = 1'b1;
            run_left_nxt = run_left - 16'd1;
          end else begin
            state_nxt = DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    s_ready_nxt = (state_nxt == LOAD) && (rem_nxt != '0);
    busy_nxt    = (state_nxt == LOAD) || (state_nxt == RUN);
    done_nxt    = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_imem_boot_seq.sv
// Randomized bench for imem_boot_seq: sessions checked against a write/run-length model.
module tb_imem_boot_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] load_base = '0;
  logic [11:0] load_count = '0;
  logic [15:0] run_cycles = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, w_enable, cpu_en, busy, done, err;
  logic [10:0] w_adrs;
  logic [31:0] w_instruction;

  imem_boot_seq #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .load_base(load_base), .load_count(load_count), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w_enable(w_enable), .w_adrs(w_adrs), .w_instruction(w_instruction),
    .cpu_en(cpu_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int          wq_c[$];
  int          wq_a[$];
  logic [31:0] wq_d[$];
  int          cpu_cnt, first_cpu, last_cpu, first_done, overlap;
  bit          done_seen;
  logic [31:0] wd[16];

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr_mon();
    wq_c.delete(); wq_a.delete(); wq_d.delete();
    cpu_cnt = 0; first_cpu = 0; last_cpu = 0; first_done = 0; done_seen = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // observe the memory port and CPU enable mid-cycle
  initial forever begin
    @(negedge clk);
    if (w_enable) begin
      wq_c.push_back(cyc);
      wq_a.push_back(int'(w_adrs));
      wq_d.push_back(w_instruction);
    end
    if (cpu_en) begin
      if (cpu_cnt == 0) first_cpu = cyc;
      last_cpu = cyc;
      cpu_cnt++;
    end
    if (done && !done_seen) begin
      done_seen  = 1;
      first_done = cyc;
    end
    if (w_enable && cpu_en) overlap++;
  end

  // vmode: 0 valid held high, 1 valid toggling, 2 random valid
  task automatic session(input int base, input int cnt, input int run, input int vmode,
                         input bit poke, input bit fixed);
    int s_cyc, i, k, budget, last_wr, exp_cpu0;
    int hq[$];
    bit hs, poked;
    poked = 0;
    if (!fixed) for (int j = 0; j < 16; j++) wd[j] = $urandom;
    @(posedge clk); #1;
    start = 1; load_base = 11'(base); load_count = 12'(cnt); run_cycles = 16'(run);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    clr_mon();
    i = 0; k = 0; budget = 300;
    while (i < cnt && budget > 0) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = (k % 2 == 0);
        default: s_valid = 1'($urandom % 2);
      endcase
      s_data = wd[i];
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) hq.push_back(cyc);
      @(posedge clk); #1;
      if (hs) i++;
      k++; budget--;
    end
    s_valid = 0;
    chk("load_words", i, cnt);
    if (cnt > 0) begin
      @(negedge clk);
      chk("rdy_drop", s_ready, 0);
    end
    budget = run + cnt + 30;
    while (!done_seen && budget > 0) begin
      @(posedge clk); #1;
      start = poke && !poked && cpu_cnt >= 2;
      if (start) begin
        poked = 1;
        load_count = 12'd5;
      end
      budget--;
    end
    start = 0;
    chk("done_seen", done_seen, 1);
    chk("n_wr", wq_c.size(), cnt);
    for (int j = 0; j < cnt && j < wq_c.size() && j < hq.size(); j++) begin
      chk("wr_adr", wq_a[j], (base + j) % 2048);
      chk("wr_dat", wq_d[j], wd[j]);
      chk("wr_lat", wq_c[j], hq[j] + 1);
      if (vmode == 0) chk("sustain", hq[j], s_cyc + 1 + j);
      if (vmode == 1) chk("gap", hq[j], s_cyc + 1 + 2 * j);
    end
    last_wr  = (wq_c.size() > 0) ? wq_c[wq_c.size()-1] : s_cyc;
    exp_cpu0 = (cnt > 0) ? last_wr + 2 : s_cyc + 2;
    chk("cpu_cnt", cpu_cnt, run);
    chk("cpu_start", first_cpu, exp_cpu0);
    chk("cpu_contig", last_cpu - first_cpu + 1, run);
    chk("done_cyc", first_done, last_cpu + 1);
    chk("overlap", overlap, 0);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("cpu_done", cpu_en, 0);
    chk("err_clean", err, 0);
  endtask

  initial begin
    int b, c, r;
    #2 resetn = 0;
    @(negedge clk);
    chk("rst_rdy", s_ready, 0);
    chk("rst_wen", w_enable, 0);
    chk("rst_cpu", cpu_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_adr", w_adrs, 0);
    chk("rst_ins", w_instruction, 0);
    @(negedge clk);
    resetn = 1;
    overlap = 0;

    wd[0] = 32'hE0030007; wd[1] = 32'hC1FFF803; wd[2] = 32'h12345678; wd[3] = 32'h80830001;
    session(4, 4, 17, 0, 0, 1);
    session(4, 4, 17, 1, 0, 1);
    session(2047, 3, 4, 0, 0, 0);
    session(0, 0, 5, 0, 0, 0);
    session(100, 2, 9, 0, 1, 0);
    for (int n = 0; n < 10; n++) begin
      b = ($urandom % 4 == 0) ? 2040 + int'($urandom % 8) : int'($urandom % 2048);
      c = $urandom_range(0, 10);
      r = $urandom_range(1, 20);
      session(b, c, r, int'($urandom % 3), (r >= 6) && ($urandom % 2 == 1), 0);
    end

    // abort alongside the second stream word
    @(posedge clk); #1;
    start = 1; load_base = 11'd4; load_count = 12'd4; run_cycles = 16'd10;
    @(posedge clk); #1;
    start = 0; clr_mon(); s_valid = 1; s_data = 32'hA5A50001;
    @(posedge clk); #1;
    s_data = 32'hA5A50002; abort = 1;
    @(posedge clk); #1;
    abort = 0; s_valid = 0;
    @(negedge clk);
    chk("ab_wen", w_enable, 0);
    chk("ab_rdy", s_ready, 0);
    chk("ab_busy", busy, 0);
    chk("ab_err", err, 1);
    repeat (4) @(negedge clk);
    chk("ab_nwr", wq_c.size(), 1);
    if (wq_c.size() > 0) begin
      chk("ab_adr", wq_a[0], 4);
      chk("ab_dat", wq_d[0], 32'hA5A50001);
    end
    @(posedge clk); #1;
    start = 1; load_count = 12'd0; run_cycles = 16'd3;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("err_clr", err, 0);
    chk("restart_busy", busy, 1);
    repeat (6) @(negedge clk);
    chk("restart_done", done, 1);

    // unlimited run, then abort
    @(posedge clk); #1;
    start = 1; load_count = 12'd0; run_cycles = 16'd0;
    @(posedge clk); #1;
    start = 0; clr_mon();
    repeat (40) @(negedge clk);
    chk("unlim_on", cpu_en, 1);
    chk("unlim_cnt", cpu_cnt, 39);
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    chk("unlim_abort_cpu", cpu_en, 0);
    chk("unlim_abort_err", err, 1);
    chk("unlim_abort_busy", busy, 0);
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    chk("err_hold_idle", err, 1);

    // reset in the middle of RUN
    @(posedge clk); #1;
    start = 1; load_count = 12'd0; run_cycles = 16'd0;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_cpu", cpu_en, 1);
    #2 resetn = 0;
    #1;
    chk("rst_async_cpu", cpu_en, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1; clr_mon(); s_valid = 1; s_data = 32'hDEADBEEF;
    repeat (10) @(negedge clk);
    chk("post_rst_wr", wq_c.size(), 0);
    chk("post_rst_cpu", cpu_cnt, 0);
    chk("post_rst_rdy", s_ready, 0);
    s_valid = 0;
    chk("overlap_total", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end

endmodule

// File: doc/imem_boot_seq.md
IMEM_BOOT_SEQ -- requirements
Module: imem_boot_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning instruction-memory address width (2048 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a load-then-run session.
REQ-006 The block SHALL have port abort  input  1  forces return to IDLE from any state.
REQ-007 The block SHALL have port load_base  input  ADDR_W  first instruction-memory address to write.
REQ-008 The block SHALL have port load_count  input  ADDR_W+1  number of words to load, 0..2048.
REQ-009 The block SHALL have port run_cycles  input  16  CPU run budget in cycles; 0 means unlimited.
REQ-010 The block SHALL have port s_valid  input  1  instruction stream word valid.
REQ-011 The block SHALL have port s_data  input  DATA_W  instruction stream word.
REQ-012 The block SHALL have port s_ready  output  1  block accepts a stream word this cycle.
REQ-013 The block SHALL have port w_enable  output  1  instruction-memory write strobe.
REQ-014 The block SHALL have port w_adrs  output  ADDR_W  instruction-memory write address.
REQ-015 The block SHALL have port w_instruction  output  DATA_W  instruction-memory write data.
REQ-016 The block SHALL have port cpu_en  output  1  CPU pipeline run enable.
REQ-017 The block SHALL have port busy  output  1  high in LOAD or RUN.
REQ-018 The block SHALL have port done  output  1  high in DONE.
REQ-019 The block SHALL have port err  output  1  sticky abort-during-session flag.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, DONE; all outputs SHALL be registered.
REQ-021 start SHALL be honored only in IDLE or DONE; start in LOAD/RUN SHALL be ignored with no side effect.
REQ-022 On an accepted start, load_base, load_count and run_cycles SHALL be latched, err SHALL clear, and the next state SHALL be LOAD (load_count>0) or RUN (load_count=0).
REQ-023 In LOAD, s_ready SHALL be 1 while remaining words >0; a word SHALL transfer when s_valid and s_ready are both 1.
REQ-024 Each transferred word SHALL produce w_enable=1 exactly one cycle later, with w_instruction=s_data and w_adrs=(load_base+index) mod 2^ADDR_W, index counting 0..load_count-1.
REQ-025 With s_valid held high, LOAD SHALL sustain one write per cycle; s_valid low SHALL insert gaps with w_enable=0.
REQ-026 On transfer of the last word, s_ready SHALL drop the next cycle and the FSM SHALL enter RUN the cycle after the last w_enable pulse.
REQ-027 w_enable and cpu_en SHALL never be 1 in the same cycle.
REQ-028 In RUN, cpu_en SHALL be 1 for exactly run_cycles consecutive cycles, then the FSM SHALL enter DONE; with run_cycles=0, cpu_en SHALL stay 1 until abort.
REQ-029 In DONE, cpu_en SHALL be 0 and done SHALL be 1 until the next accepted start or abort.
REQ-030 abort SHALL take priority over start and stream traffic: next cycle state=IDLE, cpu_en=0, w_enable=0, s_ready=0; a word presented in the abort cycle SHALL NOT be written.
REQ-031 abort in LOAD or RUN SHALL set err=1; abort in IDLE or DONE SHALL leave err unchanged.
REQ-032 Address wrap SHALL occur silently (e.g. base 2047, count 2 writes 2047 then 0).

Reset
REQ-033 While resetn=0, state SHALL be IDLE and s_ready, w_enable, cpu_en, busy, done, err SHALL be 0, with w_adrs=0 and w_instruction=0.
REQ-034 Reset assertion mid-LOAD or mid-RUN SHALL drop cpu_en and w_enable asynchronously, and no write SHALL occur after release until a new start.

Verification
REQ-035 base=4, count=4, words 0xE0030007, 0xC1FFF803, 0x12345678, 0x80830001 with s_valid held high, run_cycles=17 -> writes at addresses 4,5,6,7 on consecutive cycles, then cpu_en=1 for exactly 17 cycles, then done=1.
REQ-036 Same load with s_valid toggling 1,0,1,0 -> four w_enable pulses separated by idle cycles, and addresses remain 4..7 in order.
REQ-037 base=2047, count=3 -> w_adrs sequence 2047, 0, 1.
REQ-038 count=0, run_cycles=5 -> no w_enable, and cpu_en=1 for 5 cycles starting 2 cycles after start.
REQ-039 abort on the cycle of the 2nd stream word in count=4 -> only 1 write, IDLE next cycle, err=1; then start again -> err=0.
REQ-040 start pulsed during RUN -> ignored, and the run length is unchanged; resetn pulled low mid-RUN -> cpu_en=0 immediately.
